// File: rtl/scan_harness_pkg.sv
// Shared types and helpers for the scan I/O harness: controller states and a
// constant-evaluable ceil(log2) used to size the shift counter.
package scan_harness_pkg;

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Plain left-shifting register with a parallel load that takes priority over
// the shift; used for both the stimulus and the response chains.
module scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         sin,
  input  logic         load,
  input  logic [W-1:0] pdata,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= pdata;
    end else if (shift) begin
      q_q <= {q_q[W-2:0], sin};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/scan_io_harness.sv
// Serial-to-parallel scan harness: shifts stimulus in, applies it to the
// region under test, waits SETTLE_N cycles, captures the response and shifts it out.
module scan_io_harness
  import scan_harness_pkg::*;
#(
  parameter int DIN_N    = 256,
  parameter int DOUT_N   = 256,
  parameter int AUTO_STB = 0,
  parameter int SETTLE_N = 0,
  localparam int CW      = clog2(DIN_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              di,
  input  logic              shift_en,
  input  logic              stb,
  output logic              do_o,
  output logic [DIN_N-1:0]  roi_din,
  input  logic [DOUT_N-1:0] roi_dout,
  output logic              busy,
  output logic [CW-1:0]     bit_cnt
);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         dly_q, dly_d;
  logic [DIN_N-1:0]   roi_din_q;
  logic [DIN_N-1:0]   in_chain;
  logic [DOUT_N-1:0]  out_chain;
  logic               chain_shift, out_load, din_load;
  logic               auto_stb, strobe;

  localparam logic [CW-1:0] CNT_FULL = CW'(DIN_N);

  // The auto strobe fires on the cycle after the counter reaches full.
  assign auto_stb = (AUTO_STB != 0) && (cnt_q == CNT_FULL);
  assign strobe   = stb || auto_stb;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    chain_shift = 1'b0;
    out_load    = 1'b0;
    din_load    = 1'b0;
    unique case (state_q)
      SHIFT: begin
        if (strobe) begin
          din_load = 1'b1;
          cnt_d    = '0;
          if (SETTLE_N == 0) begin
            out_load = 1'b1;
          end else begin
            state_d = SETTLE;
            dly_d   = 8'(SETTLE_N);
          end
        end else if (shift_en) begin
          chain_shift = 1'b1;
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        dly_d = dly_q - 8'd1;
        if (dly_q == 8'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        out_load = 1'b1;
        state_d  = SHIFT;
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SHIFT;
      cnt_q     <= '0;
      dly_q     <= '0;
      roi_din_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      if (din_load) roi_din_q <= in_chain;
    end
  end

  scan_shreg #(.W(DIN_N)) u_in_chain (
    .clk   (clk),
    .rst   (rst),
    .shift (chain_shift),
    .sin   (di),
    .load  (1'b0),
    .pdata ('0),
    .q     (in_chain)
  );

  // The response chain is refilled with the stimulus as it drains.
  scan_shreg #(.W(DOUT_N)) u_out_chain (
    .clk   (clk),
    .rst   (rst),
    .shift (chain_shift),
    .sin   (in_chain[DIN_N-1]),
    .load  (out_load),
    .pdata (roi_dout),
    .q     (out_chain)
  );

  assign do_o    = out_chain[DOUT_N-1];
  assign roi_din = roi_din_q;
  assign busy    = (state_q != SHIFT);
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_scan_io_harness.sv
// Directed bench for scan_io_harness across four configurations
// (plain, SETTLE_N=3, AUTO_STB=1, SETTLE_N=5) with a queue scoreboard.
module tb_scan_io_harness;

  logic       clk = 1'b0;
  logic       rst;
  logic       di    [4];
  logic       sh    [4];
  logic       stb   [4];
  logic [7:0] rdout [4];
  logic       dout  [4];
  logic [7:0] rdin  [4];
  logic       busy  [4];
  logic [3:0] bcnt  [4];

  logic [7:0]  in_model [4];
  logic [31:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  scan_io_harness #(.DIN_N(8), .DOUT_N(8), .AUTO_STB(0), .SETTLE_N(0)) u_dut0 (
    .clk(clk), .rst(rst), .di(di[0]), .shift_en(sh[0]), .stb(stb[0]), .do_o(dout[0]),
    .roi_din(rdin[0]), .roi_dout(rdout[0]), .busy(busy[0]), .bit_cnt(bcnt[0]));
  scan_io_harness #(.DIN_N(8), .DOUT_N(8), .AUTO_STB(0), .SETTLE_N(3)) u_dut1 (
    .clk(clk), .rst(rst), .di(di[1]), .shift_en(sh[1]), .stb(stb[1]), .do_o(dout[1]),
    .roi_din(rdin[1]), .roi_dout(rdout[1]), .busy(busy[1]), .bit_cnt(bcnt[1]));
  scan_io_harness #(.DIN_N(8), .DOUT_N(8), .AUTO_STB(1), .SETTLE_N(0)) u_dut2 (
    .clk(clk), .rst(rst), .di(di[2]), .shift_en(sh[2]), .stb(stb[2]), .do_o(dout[2]),
    .roi_din(rdin[2]), .roi_dout(rdout[2]), .busy(busy[2]), .bit_cnt(bcnt[2]));
  scan_io_harness #(.DIN_N(8), .DOUT_N(8), .AUTO_STB(0), .SETTLE_N(5)) u_dut3 (
    .clk(clk), .rst(rst), .di(di[3]), .shift_en(sh[3]), .stb(stb[3]), .do_o(dout[3]),
    .roi_din(rdin[3]), .roi_dout(rdout[3]), .busy(busy[3]), .bit_cnt(bcnt[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic push_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sb_q.push_back({31'd0, v[i]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input int k, input logic b);
    di[k] = b;
    sh[k] = 1'b1;
    tick();
    sh[k] = 1'b0;
    in_model[k] = {in_model[k][6:0], b};
  endtask

  initial begin
    logic [7:0] pat;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      di[k] = 1'b0; sh[k] = 1'b0; stb[k] = 1'b0; rdout[k] = 8'h00; in_model[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_roi_din%0d", k), rdin[k], 0);
      check($sformatf("rst_busy%0d", k), busy[k], 0);
      check($sformatf("rst_do%0d", k), dout[k], 0);
      check($sformatf("rst_bit_cnt%0d", k), bcnt[k], 0);
    end
    rst = 1'b0;

    // Plain configuration: first edge after reset shifts, then A5 in / 3C out.
    shift_bit(0, 1'b1);
    check("first_edge_cnt", bcnt[0], 1);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) shift_bit(0, pat[i]);
    check("cnt_sat9", bcnt[0], 8);
    rdout[0] = 8'h3C;
    stb[0] = 1'b1;
    sb_q.push_back({24'd0, in_model[0]});
    push_bits(8'h3C);
    push_bits(8'hA5);
    tick();
    stb[0] = 1'b0;
    sb_check("roi_din_A5", rdin[0]);
    check("cnt_after_stb", bcnt[0], 0);
    for (int i = 0; i < 16; i++) begin
      sb_check($sformatf("do_bit%0d", i), dout[0]);
      shift_bit(0, 1'b0);
    end
    check("cnt_sat16", bcnt[0], 8);

    // Strobe and shift together: strobe wins, no shift happens.
    shift_bit(0, 1'b1);
    shift_bit(0, 1'b1);
    shift_bit(0, 1'b0);
    stb[0] = 1'b1; sh[0] = 1'b1; di[0] = 1'b1;
    sb_q.push_back({24'd0, in_model[0]});
    tick();
    sh[0] = 1'b0;
    sb_check("stb_shift_roi_din", rdin[0]);
    check("stb_shift_cnt", bcnt[0], 0);
    sb_q.push_back({24'd0, in_model[0]});
    tick();
    stb[0] = 1'b0;
    sb_check("in_chain_held", rdin[0]);

    // SETTLE_N=3: saturate with 12 shifts, then time the settle window.
    for (int i = 0; i < 4; i++) shift_bit(1, 1'b0);
    pat = 8'h5A;
    for (int i = 7; i >= 0; i--) shift_bit(1, pat[i]);
    check("sat12_cnt", bcnt[1], 8);
    rdout[1] = 8'h11;
    stb[1] = 1'b1;
    sb_q.push_back({24'd0, in_model[1]});
    tick();
    stb[1] = 1'b0;
    check("busy_T1", busy[1], 1);
    sb_check("settle_roi_din", rdin[1]);
    tick();
    check("busy_T2", busy[1], 1);
    stb[1] = 1'b1; sh[1] = 1'b1; di[1] = 1'b1;
    tick();
    stb[1] = 1'b0; sh[1] = 1'b0;
    check("busy_T3", busy[1], 1);
    check("cnt_held_settle", bcnt[1], 0);
    tick();
    check("busy_T4", busy[1], 1);
    rdout[1] = 8'hC3;
    push_bits(8'hC3);
    tick();
    check("busy_T5", busy[1], 0);
    for (int i = 0; i < 8; i++) begin
      sb_check($sformatf("settle_do%0d", i), dout[1]);
      shift_bit(1, 1'b0);
    end
    check("no_queued_stb_cnt", bcnt[1], 8);
    check("no_queued_stb_busy", busy[1], 0);

    // AUTO_STB: strobe one cycle after the 8th shift.
    for (int i = 0; i < 8; i++) shift_bit(2, 1'b1);
    check("auto_cnt_full", bcnt[2], 8);
    check("auto_not_yet", rdin[2], 0);
    sb_q.push_back(32'hFF);
    tick();
    sb_check("auto_roi_din", rdin[2]);
    check("auto_cnt_clr", bcnt[2], 0);
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) shift_bit(2, pat[i]);
    stb[2] = 1'b1;
    sb_q.push_back(32'h3C);
    tick();
    stb[2] = 1'b0;
    sb_check("auto_ext_roi_din", rdin[2]);
    check("auto_ext_cnt", bcnt[2], 0);

    // SETTLE_N=5: asynchronous reset mid-settle aborts the capture.
    pat = 8'h81;
    for (int i = 7; i >= 0; i--) shift_bit(3, pat[i]);
    rdout[3] = 8'hFF;
    stb[3] = 1'b1;
    tick();
    stb[3] = 1'b0;
    tick();
    tick();
    check("mid_settle_busy", busy[3], 1);
    rst = 1'b1;
    #1;
    check("async_busy", busy[3], 0);
    check("async_do", dout[3], 0);
    check("async_roi_din", rdin[3], 0);
    check("async_cnt", bcnt[3], 0);
    tick();
    rst = 1'b0;
    shift_bit(3, 1'b0);
    check("post_rst_first_edge", bcnt[3], 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("abort_busy%0d", i), busy[3], 0);
      check($sformatf("abort_do%0d", i), dout[3], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
